// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, runs one instruction-memory request at a time and hands
// each word plus its PC+4 to IF/ID. Optional misaligned-target trap: FETCH_ALIGN_CHECK_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clock_i,
    input  logic        Reset_i,
    input  logic        Start_i,
    input  logic        Stall_i,
    input  logic        Branch_i,
    input  logic [31:0] Target_i,
    output logic        IMemReq_o,
    output logic [31:0] IMemAddr_o,
    input  logic        IMemAck_i,
    input  logic [31:0] IMemData_i,
    output logic [31:0] PC_o,
    output logic [31:0] PC4_o,
    output logic [31:0] Inst_o,
    output logic        IFID_o,
    output logic        Flush_o
`ifdef FETCH_ALIGN_CHECK_EN
   ,output logic        AddrErr_o
`endif
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] req_addr, req_addr_nx;
    logic [31:0] inst, inst_nx;
    logic [31:0] pc4, pc4_nx;
    logic [31:0] tgt;
    logic        bad_tgt;
    logic        err;
    logic        go;

`ifdef FETCH_ALIGN_CHECK_EN
    assign tgt     = Target_i;
    assign bad_tgt = Branch_i && (Target_i[1:0] != 2'b00);

    // Sticky: once a misaligned redirect is seen, nothing new is fetched until reset.
    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) err <= 1'b0;
        else         err <= err | bad_tgt;
    end
    assign AddrErr_o = err;
`else
    assign tgt     = Target_i & 32'hFFFF_FFFC;
    assign bad_tgt = 1'b0;
    assign err     = 1'b0;
`endif

    assign go = Start_i && !err && !bad_tgt;

    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            inst     <= 32'h0;
            pc4      <= 32'h0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_addr <= req_addr_nx;
            inst     <= inst_nx;
            pc4      <= pc4_nx;
        end
    end

    // A redirect always wins; with Start_i low every exit that would refetch goes IDLE.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_addr_nx = req_addr;
        inst_nx     = inst;
        pc4_nx      = pc4;
        IMemReq_o   = 1'b0;
        IFID_o      = 1'b0;
        Flush_o     = 1'b0;
        case (state)
            IDLE: begin
                if (Branch_i) begin
                    pc_nx   = tgt;
                    Flush_o = bad_tgt;
                end else if (go) begin
                    state_nx    = FETCH;
                    req_addr_nx = pc;
                end
            end
            FETCH: begin
                IMemReq_o = 1'b1;
                if (Branch_i) begin
                    Flush_o = 1'b1;
                    pc_nx   = tgt;
                    if (IMemAck_i) begin
                        state_nx    = go ? FETCH : IDLE;
                        req_addr_nx = go ? tgt : req_addr;
                    end else begin
                        state_nx = DRAIN;
                    end
                end else if (IMemAck_i) begin
                    inst_nx  = IMemData_i;
                    pc4_nx   = req_addr + 32'd4;
                    pc_nx    = req_addr + 32'd4;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (Branch_i) begin
                    Flush_o     = 1'b1;
                    pc_nx       = tgt;
                    state_nx    = go ? FETCH : IDLE;
                    req_addr_nx = go ? tgt : req_addr;
                end else if (!Stall_i) begin
                    IFID_o      = 1'b1;
                    state_nx    = go ? FETCH : IDLE;
                    req_addr_nx = go ? pc : req_addr;
                end
            end
            DRAIN: begin
                IMemReq_o = 1'b1;
                if (Branch_i) begin
                    Flush_o = 1'b1;
                    pc_nx   = tgt;
                end
                // Returned word belongs to a squashed path; drop it.
                if (IMemAck_i) begin
                    state_nx    = go ? FETCH : IDLE;
                    req_addr_nx = go ? pc_nx : req_addr;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign IMemAddr_o = req_addr;
    assign PC_o       = pc;
    assign PC4_o      = pc4;
    assign Inst_o     = inst;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios pinned with literal values, then
// randomized traffic checked every cycle against a request/buffer-level model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        Reset_i, Start_i, Stall_i, Branch_i, IMemAck_i;
    logic [31:0] Target_i, IMemData_i;
    logic        IMemReq_o, IFID_o, Flush_o;
    logic [31:0] IMemAddr_o, PC_o, PC4_o, Inst_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        AddrErr_o;
`endif

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(32'h0)) dut (
        .Clock_i(clk), .Reset_i(Reset_i), .Start_i(Start_i), .Stall_i(Stall_i),
        .Branch_i(Branch_i), .Target_i(Target_i), .IMemReq_o(IMemReq_o),
        .IMemAddr_o(IMemAddr_o), .IMemAck_i(IMemAck_i), .IMemData_i(IMemData_i),
        .PC_o(PC_o), .PC4_o(PC4_o), .Inst_o(Inst_o), .IFID_o(IFID_o), .Flush_o(Flush_o)
`ifdef FETCH_ALIGN_CHECK_EN
       ,.AddrErr_o(AddrErr_o)
`endif
    );

    // Model: an outstanding request (possibly doomed), a one-entry buffer, and the PC.
    bit          m_req, m_drop, m_buf;
    logic [31:0] m_pc, m_addr, m_inst, m_pc4;
    int          lat, cnt, fix_lat;
    bit          spur_en, model_on, prev_req;
    int          n_vec, n_err, cyc;
    logic        s_ifid, s_flush, s_req;
    logic [31:0] s_addr, s_pc4, s_pc;
    logic [31:0] d_pc4[$], req_log[$];
    int          d_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int new_lat();
        return (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 3));
    endfunction

    task automatic model_reset();
        m_req = 0; m_drop = 0; m_buf = 0;
        m_pc = 0; m_addr = 0; m_inst = 0; m_pc4 = 0;
        cnt = 0; lat = new_lat();
    endtask

    task automatic model_update(input bit s, input bit st, input bit br,
                                input logic [31:0] tg, input bit ack, input logic [31:0] d);
        logic [31:0] t;
        t = tg & 32'hFFFF_FFFC;
        if (m_buf) begin
            if (br) begin
                m_buf = 0; m_pc = t;
                if (s) begin m_req = 1; m_drop = 0; m_addr = t; end
            end else if (!st) begin
                m_buf = 0;
                if (s) begin m_req = 1; m_drop = 0; m_addr = m_pc; end
            end
        end else if (m_req) begin
            if (br) m_pc = t;
            if (ack) begin
                m_req = 0;
                if (!m_drop && !br) begin
                    m_buf = 1; m_inst = d; m_pc4 = m_addr + 4; m_pc = m_addr + 4;
                end else if (s) begin
                    m_req = 1; m_addr = m_pc;
                end
                m_drop = 0;
            end else if (br) begin
                m_drop = 1;
            end
        end else begin
            if (br) m_pc = t;
            else if (s) begin m_req = 1; m_drop = 0; m_addr = m_pc; end
        end
    endtask

    // One clock: drive at negedge, compare #1 later, advance model at posedge.
    task automatic step(input bit s, input bit st, input bit br, input logic [31:0] tg,
                        input bit rst = 0);
        bit was_req;
        @(negedge clk);
        Reset_i = rst; Start_i = s; Stall_i = st; Branch_i = br; Target_i = tg;
        IMemData_i = $urandom;
        if (rst) model_reset();
        if (m_req) IMemAck_i = (cnt >= lat);
        else       IMemAck_i = spur_en && ($urandom_range(0, 7) == 0);
        #1;
        s_ifid = IFID_o; s_flush = Flush_o; s_req = IMemReq_o;
        s_addr = IMemAddr_o; s_pc4 = PC4_o; s_pc = PC_o;
        if (s_ifid) begin d_pc4.push_back(PC4_o); d_cyc.push_back(cyc); end
        if (s_req && !prev_req) req_log.push_back(s_addr);
        prev_req = s_req;
        if (model_on) begin
            chk("imem_req", IMemReq_o, m_req);
            if (m_req) chk("imem_addr", IMemAddr_o, m_addr);
            chk("pc", PC_o, m_pc);
            chk("ifid", IFID_o, m_buf && !st && !br);
            chk("flush", Flush_o, br && (m_req || m_buf));
            if (m_buf) begin
                chk("inst", Inst_o, m_inst);
                chk("pc4", PC4_o, m_pc4);
            end
        end
        @(posedge clk);
        cyc++;
        if (!rst) begin
            was_req = m_req;
            if (was_req) begin
                if (IMemAck_i) begin cnt = 0; lat = new_lat(); end
                else cnt++;
            end
            model_update(s, st, br, tg, IMemAck_i, IMemData_i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int ifid_seen;
        logic [31:0] tg;
        Reset_i = 1; Start_i = 0; Stall_i = 0; Branch_i = 0; Target_i = 0;
        IMemAck_i = 0; IMemData_i = 0;
        n_vec = 0; n_err = 0; cyc = 0; prev_req = 0;
        model_on = 1; spur_en = 0; fix_lat = 2;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req", IMemReq_o, 0);
        chk("rst_addr", IMemAddr_o, 32'h0);
        chk("rst_pc", PC_o, 32'h0);
        chk("rst_pc4", PC4_o, 32'h0);
        chk("rst_inst", Inst_o, 32'h0);
        chk("rst_ifid", IFID_o, 0);
        chk("rst_flush", Flush_o, 0);

        // Latency 2: one delivery every 4 cycles, requests at 0,4,8.
        repeat (13) step(1, 0, 0, 0);
        chk("tp_count", d_pc4.size(), 3);
        if (d_pc4.size() >= 3 && req_log.size() >= 3) begin
            chk("tp_pc4_0", d_pc4[0], 32'd4);
            chk("tp_pc4_1", d_pc4[1], 32'd8);
            chk("tp_pc4_2", d_pc4[2], 32'd12);
            chk("tp_gap", d_cyc[2] - d_cyc[1], 4);
            chk("tp_req_0", req_log[0], 32'd0);
            chk("tp_req_1", req_log[1], 32'd4);
            chk("tp_req_2", req_log[2], 32'd8);
        end

        // Stall held 3 cycles in HOLD, then released once.
        for (int k = 0; k < 20 && !m_buf; k++) step(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0);
            chk("stall_ifid", s_ifid, 0);
            chk("stall_req", s_req, 0);
            chk("stall_pc4", s_pc4, 32'd16);
        end
        step(1, 0, 0, 0);
        chk("release_ifid", s_ifid, 1);
        chk("release_pc4", s_pc4, 32'd16);

        // Redirect while the request is outstanding: flush, drain, refetch at 0x100.
        step(1, 0, 1, 32'h100);
        chk("br_flush", s_flush, 1);
        chk("br_ifid", s_ifid, 0);
        found = 0; ifid_seen = 0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(1, 0, 0, 0);
            if (s_ifid) ifid_seen++;
            if (s_req && s_addr == 32'h100) found = 1;
        end
        chk("drain_refetch", found, 1);
        chk("drain_no_deliver", ifid_seen, 0);
        for (int k = 0; k < 10; k++) begin step(1, 0, 0, 0); if (s_ifid) break; end
        chk("br_pc4", s_pc4, 32'h104);

        // Branch and stall together in HOLD.
        for (int k = 0; k < 20 && !m_buf; k++) step(1, 0, 0, 0);
        step(1, 1, 1, 32'h200);
        chk("bs_flush", s_flush, 1);
        chk("bs_ifid", s_ifid, 0);
        step(1, 0, 0, 0);
        chk("bs_req", s_req, 1);
        chk("bs_addr", s_addr, 32'h200);

        // Wrap at the top of the address space.
        step(1, 0, 1, 32'hFFFF_FFFC);
        for (int k = 0; k < 15; k++) begin step(1, 0, 0, 0); if (s_ifid) break; end
        chk("wrap_pc4", s_pc4, 32'h0);
        for (int k = 0; k < 5; k++) begin step(1, 0, 0, 0); if (s_req) break; end
        chk("wrap_req", s_addr, 32'h0);

`ifndef FETCH_ALIGN_CHECK_EN
        // Start low finishes current work; an IDLE branch only loads PC (low bits cleared).
        for (int k = 0; k < 15 && (m_req || m_buf); k++) step(0, 0, 0, 0);
        step(0, 0, 1, 32'h302);
        chk("idle_br_flush", s_flush, 0);
        step(0, 0, 0, 0);
        chk("idle_br_pc", s_pc, 32'h300);
        chk("idle_req", s_req, 0);
`endif

        // Randomized traffic with random latency, spurious acks and occasional resets.
        spur_en = 1; fix_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            tg = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            tg = tg & 32'hFFFF_FFFC;
`endif
            if ($urandom_range(0, 15) == 0) tg = 32'hFFFF_FFF0 | (tg & 32'hC);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, tg, $urandom_range(0, 299) == 0);
        end

`ifdef FETCH_ALIGN_CHECK_EN
        // Misaligned redirect from HOLD: sticky error, no further requests.
        spur_en = 0;
        step(0, 0, 0, 0, 1);
        for (int k = 0; k < 20 && !m_buf; k++) step(1, 0, 0, 0);
        step(1, 1, 1, 32'h102);
        chk("align_flush", s_flush, 1);
        model_on = 0;
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 0);
            chk("align_no_req", s_req, 0);
        end
        chk("align_err", AddrErr_o, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
